// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, types and helpers for the maze tile store.
//   MAZE_W/MAZE_H/TILES : maze geometry (40x30 tiles)
//   WALL_B/PELLET_B/POWER_B : bit positions inside a tile word
//   upd_op_t : update opcode carried on upd_op
//   state_t  : tile writer FSM states
//   has_pellet() : tile word holds a pellet or a power pellet
package maze_pkg;

  localparam int MAZE_W   = 40;
  localparam int MAZE_H   = 30;
  localparam int TILES    = MAZE_W * MAZE_H;
  localparam int WORD_W   = 5;
  localparam int WALL_B   = 0;
  localparam int PELLET_B = 1;
  localparam int POWER_B  = 2;

  typedef enum logic [1:0] {
    OP_CLR_PELLET = 2'd0,
    OP_CLR_POWER  = 2'd1,
    OP_WRITE      = 2'd2,
    OP_RSVD       = 2'd3
  } upd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RST_SWEEP,
    ST_RST_DONE
  } state_t;

  function automatic logic has_pellet(input logic [WORD_W-1:0] word);
    return word[PELLET_B] | word[POWER_B];
  endfunction

endpackage

// File: rtl/maze_restore_sweep.sv
// maze_restore_sweep: copies the pristine maze ROM into the tile RAM.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : begin a sweep; the next cycle is sweep cycle k=0
//   i_rom_data     : ROM data, valid one cycle after o_rom_addr
//   o_rom_addr     : ROM address, equals k during sweep cycles 0..TILES-1
//   o_wr_en/o_wr_addr/o_wr_data : RAM write, lagging the ROM address by one cycle
//   o_busy         : sweep cycles 0..TILES
//   o_last         : final busy cycle (k == TILES)
//   o_done         : one-cycle pulse in cycle TILES+1
//   o_pellet_cnt   : number of copied words holding a pellet (final in the done cycle)
module maze_restore_sweep
  import maze_pkg::*;
#(
  parameter int TILES = 1200,
  parameter int AW    = 11,
  parameter int DW    = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_rom_data,
  output logic [AW-1:0] o_rom_addr,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_busy,
  output logic          o_last,
  output logic          o_done,
  output logic [AW-1:0] o_pellet_cnt
);

  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_pcnt;
  logic          r_busy;
  logic          r_wr_en;
  logic          r_done;
  logic          w_last;
  logic          w_reading;

  assign w_last    = r_busy && (r_cnt == AW'(TILES));
  assign w_reading = r_busy && !w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_wr_addr <= '0;
      r_pcnt    <= '0;
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done    <= w_last;
      // The write trails the ROM read by one cycle to absorb ROM latency.
      r_wr_en   <= w_reading;
      r_wr_addr <= w_reading ? r_cnt : '0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_pcnt <= '0;
      end else if (r_busy) begin
        if (w_last) begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + AW'(1);
        end
        if (r_wr_en && has_pellet(i_rom_data)) begin
          r_pcnt <= r_pcnt + AW'(1);
        end
      end
    end
  end

  assign o_rom_addr   = w_reading ? r_cnt : '0;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = i_rom_data;
  assign o_busy       = r_busy;
  assign o_last       = w_last;
  assign o_done       = r_done;
  assign o_pellet_cnt = r_pcnt;

endmodule

// File: rtl/maze_tile_writer.sv
// maze_tile_writer: write side of the 40x30 maze tile RAM.
//   Clk, Reset_n            : clock, asynchronous active-low reset
//   upd_valid/upd_ready     : update handshake; upd_tile/upd_op/upd_data payload
//   ram_rd_addr/ram_rd_data : RAM read port (1-cycle latency)
//   ram_wr_en/addr/data     : RAM write port
//   rom_addr/rom_data       : pristine maze ROM (1-cycle latency)
//   restore_start/busy/done : level-restore sweep control and status
//   pellet_eaten/power_eaten/bad_tile/level_clear : one-cycle event pulses
//   pellets_left            : tiles still holding a pellet or power pellet
module maze_tile_writer
  import maze_pkg::*;
#(
  parameter int TILES = 1200,
  parameter int AW    = 11,
  parameter int DW    = 5
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          upd_valid,
  output logic          upd_ready,
  input  logic [AW-1:0] upd_tile,
  input  logic [1:0]    upd_op,
  input  logic [DW-1:0] upd_data,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          restore_start,
  output logic          restore_busy,
  output logic          restore_done,
  output logic          pellet_eaten,
  output logic          power_eaten,
  output logic          bad_tile,
  output logic [AW-1:0] pellets_left,
  output logic          level_clear
);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_tile;
  upd_op_t       r_op;
  logic [DW-1:0] r_data;
  logic          r_bad;
  logic          r_pend;
  logic [AW-1:0] r_pellets;

  logic          w_hs;
  logic          w_start;
  logic          w_in_wr;
  logic [DW-1:0] w_new;
  logic          w_pe;
  logic          w_pw;
  logic          w_dec;
  logic          w_inc;
  logic          w_upd_wr;

  logic          w_sw_wr_en;
  logic [AW-1:0] w_sw_wr_addr;
  logic [DW-1:0] w_sw_wr_data;
  logic [AW-1:0] w_sw_rom_addr;
  logic          w_sw_busy;
  logic          w_sw_last;
  logic          w_sw_done;
  logic [AW-1:0] w_sw_pcnt;

  // A pending restore takes priority over new updates once back in IDLE.
  assign w_start = (r_state == ST_IDLE) && (restore_start || r_pend);
  assign w_hs    = upd_valid && upd_ready;
  assign w_in_wr = (r_state == ST_WR);

  maze_restore_sweep #(
    .TILES (TILES),
    .AW    (AW),
    .DW    (DW)
  ) u_sweep (
    .i_clk        (Clk),
    .i_rst_n      (Reset_n),
    .i_start      (w_start),
    .i_rom_data   (rom_data),
    .o_rom_addr   (w_sw_rom_addr),
    .o_wr_en      (w_sw_wr_en),
    .o_wr_addr    (w_sw_wr_addr),
    .o_wr_data    (w_sw_wr_data),
    .o_busy       (w_sw_busy),
    .o_last       (w_sw_last),
    .o_done       (w_sw_done),
    .o_pellet_cnt (w_sw_pcnt)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start)   w_state_next = ST_RST_SWEEP;
        else if (w_hs) w_state_next = ST_RD;
      end
      ST_RD:        w_state_next = r_bad ? ST_IDLE : ST_WR;
      ST_WR:        w_state_next = ST_IDLE;
      ST_RST_SWEEP: if (w_sw_last) w_state_next = ST_RST_DONE;
      ST_RST_DONE:  w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // Read-modify-write result, meaningful only in the WR cycle.
  always_comb begin
    w_new = ram_rd_data;
    w_pe  = 1'b0;
    w_pw  = 1'b0;
    case (r_op)
      OP_CLR_PELLET: begin
        if (!ram_rd_data[WALL_B] && ram_rd_data[PELLET_B]) begin
          w_new[PELLET_B] = 1'b0;
          w_pe            = 1'b1;
        end
      end
      OP_CLR_POWER: begin
        if (!ram_rd_data[WALL_B] && ram_rd_data[POWER_B]) begin
          w_new[POWER_B] = 1'b0;
          w_pw           = 1'b1;
        end
      end
      OP_WRITE: w_new = r_data;
      default:  w_new = ram_rd_data;
    endcase
    w_dec = w_pe || w_pw ||
            ((r_op == OP_WRITE) && has_pellet(ram_rd_data) && !has_pellet(r_data));
    w_inc = (r_op == OP_WRITE) && !has_pellet(ram_rd_data) && has_pellet(r_data);
  end

  always_comb begin
    w_upd_wr     = w_in_wr && (w_new != ram_rd_data);
    upd_ready    = (r_state == ST_IDLE) && !restore_start && !r_pend;
    ram_rd_addr  = ((r_state == ST_RD) && !r_bad) ? r_tile : '0;
    ram_wr_en    = w_sw_wr_en || w_upd_wr;
    ram_wr_addr  = w_sw_wr_en ? w_sw_wr_addr : (w_upd_wr ? r_tile : '0);
    ram_wr_data  = w_sw_wr_en ? w_sw_wr_data : (w_upd_wr ? w_new : '0);
    rom_addr     = w_sw_rom_addr;
    restore_busy = w_sw_busy;
    restore_done = w_sw_done;
    pellet_eaten = w_in_wr && w_pe;
    power_eaten  = w_in_wr && w_pw;
    bad_tile     = (r_state == ST_RD) && r_bad;
    level_clear  = w_in_wr && w_dec && (r_pellets == AW'(1));
    // Show the freshly swept count in the done cycle itself.
    pellets_left = (r_state == ST_RST_DONE) ? w_sw_pcnt : r_pellets;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tile    <= '0;
      r_op      <= OP_CLR_PELLET;
      r_data    <= '0;
      r_bad     <= 1'b0;
      r_pend    <= 1'b0;
      r_pellets <= '0;
    end else begin
      if (w_hs) begin
        r_tile <= upd_tile;
        r_op   <= upd_op_t'(upd_op);
        r_data <= upd_data;
        r_bad  <= (upd_tile >= AW'(TILES));
      end
      if (w_start) begin
        r_pend <= 1'b0;
      end else if (restore_start && ((r_state == ST_RD) || (r_state == ST_WR))) begin
        r_pend <= 1'b1;
      end
      // Count saturates at both ends rather than wrapping.
      if (r_state == ST_RST_DONE) begin
        r_pellets <= w_sw_pcnt;
      end else if (w_in_wr && w_dec && (r_pellets != '0)) begin
        r_pellets <= r_pellets - AW'(1);
      end else if (w_in_wr && w_inc && (r_pellets != {AW{1'b1}})) begin
        r_pellets <= r_pellets + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_maze_tile_writer.sv
module tb_maze_tile_writer;

  localparam int NT = 1200;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [10:0] upd_tile = '0;
  logic [1:0]  upd_op = '0;
  logic [4:0]  upd_data = '0;
  logic [10:0] ram_rd_addr;
  logic [4:0]  ram_rd_data;
  logic        ram_wr_en;
  logic [10:0] ram_wr_addr;
  logic [4:0]  ram_wr_data;
  logic [10:0] rom_addr;
  logic [4:0]  rom_data;
  logic        restore_start = 1'b0;
  logic        restore_busy;
  logic        restore_done;
  logic        pellet_eaten;
  logic        power_eaten;
  logic        bad_tile;
  logic [10:0] pellets_left;
  logic        level_clear;

  maze_tile_writer dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_tile      (upd_tile),
    .upd_op        (upd_op),
    .upd_data      (upd_data),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_data   (ram_rd_data),
    .ram_wr_en     (ram_wr_en),
    .ram_wr_addr   (ram_wr_addr),
    .ram_wr_data   (ram_wr_data),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .restore_start (restore_start),
    .restore_busy  (restore_busy),
    .restore_done  (restore_done),
    .pellet_eaten  (pellet_eaten),
    .power_eaten   (power_eaten),
    .bad_tile      (bad_tile),
    .pellets_left  (pellets_left),
    .level_clear   (level_clear)
  );

  always #5 Clk = ~Clk;

  logic [4:0] ram   [0:NT-1];
  logic [4:0] rom   [0:NT-1];
  logic [4:0] model [0:NT-1];
  int pl = 0;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, pe_cnt = 0, pw_cnt = 0, lc_cnt = 0, bad_cnt = 0;

  // RAM and ROM behavioural memories, both with a 1-cycle registered read.
  always @(posedge Clk) begin
    if (ram_wr_en && (ram_wr_addr < 11'(NT))) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= (ram_rd_addr < 11'(NT)) ? ram[ram_rd_addr] : 5'd0;
    rom_data    <= (rom_addr < 11'(NT)) ? rom[rom_addr] : 5'd0;
  end

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (ram_wr_en)    wr_cnt  <= wr_cnt + 1;
      if (pellet_eaten) pe_cnt  <= pe_cnt + 1;
      if (power_eaten)  pw_cnt  <= pw_cnt + 1;
      if (level_clear)  lc_cnt  <= lc_cnt + 1;
      if (bad_tile)     bad_cnt <= bad_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One update transaction, checked cycle by cycle against the tile rules.
  // With rs_in_rd set, restore_start is pulsed in the RD cycle and upd_valid stays high.
  task automatic do_update(input int tile, input int op, input logic [4:0] data, input bit rs_in_rd);
    logic [4:0] old_v, new_v;
    bit bad, pe, pw, lc, chg;
    int exp_pl, n, wr0, pe0, pw0, lc0, bd0;
    bad = (tile >= NT);
    old_v = bad ? 5'd0 : model[tile];
    new_v = old_v;
    pe = 0; pw = 0;
    if (!bad) begin
      case (op)
        0: if (!old_v[0] && old_v[1]) begin new_v[1] = 1'b0; pe = 1; end
        1: if (!old_v[0] && old_v[2]) begin new_v[2] = 1'b0; pw = 1; end
        2: new_v = data;
        default: ;
      endcase
    end
    chg = !bad && (new_v != old_v);
    exp_pl = pl;
    if (pe || pw) exp_pl = pl - 1;
    else if (!bad && op == 2) exp_pl = pl + int'(new_v[1] | new_v[2]) - int'(old_v[1] | old_v[2]);
    if (exp_pl < 0) exp_pl = 0;
    lc = (pl == 1) && (exp_pl == 0);

    @(posedge Clk); #1;
    upd_valid = 1'b1; upd_tile = 11'(tile); upd_op = 2'(op); upd_data = data;
    wr0 = wr_cnt; pe0 = pe_cnt; pw0 = pw_cnt; lc0 = lc_cnt; bd0 = bad_cnt;
    n = 0;
    @(negedge Clk);
    while (!upd_ready && n < 3000) begin @(negedge Clk); n++; end
    check("handshake_ready", 32'(upd_ready), 1);
    if (!upd_ready) begin upd_valid = 1'b0; return; end
    @(posedge Clk); #1;
    if (rs_in_rd) restore_start = 1'b1;
    else upd_valid = 1'b0;
    @(negedge Clk);                                   // T+1
    check("bad_tile_t1", 32'(bad_tile), 32'(bad));
    if (!bad) check("rd_addr_t1", 32'(ram_rd_addr), tile);
    if (rs_in_rd) begin @(posedge Clk); #1 restore_start = 1'b0; end
    @(negedge Clk);                                   // T+2
    check("ready_t2", 32'(upd_ready), 32'(bad));
    if (!bad) begin
      check("wr_en_t2", 32'(ram_wr_en), 32'(chg));
      if (chg) begin
        check("wr_addr_t2", 32'(ram_wr_addr), tile);
        check("wr_data_t2", 32'(ram_wr_data), 32'(new_v));
      end
      check("pellet_eaten_t2", 32'(pellet_eaten), 32'(pe));
      check("power_eaten_t2", 32'(power_eaten), 32'(pw));
      check("level_clear_t2", 32'(level_clear), 32'(lc));
    end
    @(negedge Clk);                                   // T+3
    check("ready_t3", 32'(upd_ready), 32'(!rs_in_rd));
    check("pellets_left", 32'(pellets_left), exp_pl);
    check("ram_write_count", wr_cnt - wr0, 32'(chg));
    check("pellet_pulses", pe_cnt - pe0, 32'(pe));
    check("power_pulses", pw_cnt - pw0, 32'(pw));
    check("level_clear_pulses", lc_cnt - lc0, 32'(lc));
    check("bad_tile_pulses", bad_cnt - bd0, 32'(bad));
    if (!bad) model[tile] = new_v;
    pl = exp_pl;
    $display("update tile=%0d op=%0d data=%b old=%b new=%b pellets_left=%0d", tile, op, data, old_v, new_v, exp_pl);
  endtask

  // Called just after the clock edge that begins sweep cycle k=0.
  task automatic sweep_check();
    int exp_cnt, wr0, ev0, mism;
    bit busy_ok, addr_ok, rdy_ok;
    exp_cnt = 0; busy_ok = 1; addr_ok = 1; rdy_ok = 1; mism = 0;
    for (int i = 0; i < NT; i++) exp_cnt += int'(rom[i][1] | rom[i][2]);
    wr0 = wr_cnt; ev0 = pe_cnt + pw_cnt + lc_cnt;
    for (int k = 0; k <= NT; k++) begin
      @(negedge Clk);
      if (restore_busy !== 1'b1) busy_ok = 0;
      if (k < NT && rom_addr !== 11'(k)) addr_ok = 0;
      if (upd_ready !== 1'b0) rdy_ok = 0;
    end
    check("sweep_busy", 32'(busy_ok), 1);
    check("sweep_rom_addr", 32'(addr_ok), 1);
    check("sweep_not_ready", 32'(rdy_ok), 1);
    @(negedge Clk);                                   // cycle TILES+1
    check("restore_done", 32'(restore_done), 1);
    check("busy_after_sweep", 32'(restore_busy), 0);
    check("pellets_after_restore", 32'(pellets_left), exp_cnt);
    check("ready_in_done", 32'(upd_ready), 0);
    @(posedge Clk); #1 upd_valid = 1'b0;
    @(negedge Clk);
    check("done_single_cycle", 32'(restore_done), 0);
    check("ready_after_restore", 32'(upd_ready), 1);
    check("sweep_write_count", wr_cnt - wr0, NT);
    check("sweep_no_events", pe_cnt + pw_cnt + lc_cnt - ev0, 0);
    for (int i = 0; i < NT; i++) if (ram[i] !== rom[i]) mism++;
    check("ram_matches_rom", mism, 0);
    for (int i = 0; i < NT; i++) model[i] = rom[i];
    pl = exp_cnt;
    $display("restore complete pellets_left=%0d", exp_cnt);
  endtask

  task automatic do_restore();
    @(posedge Clk); #1 restore_start = 1'b1;
    @(negedge Clk);
    check("ready_low_on_start", 32'(upd_ready), 0);
    @(posedge Clk); #1 restore_start = 1'b0;
    sweep_check();
  endtask

  initial begin
    for (int i = 0; i < NT; i++) begin
      ram[i]   = 5'($urandom_range(0, 31));
      rom[i]   = (i % 40 == 0) ? 5'b00001 : 5'b00000;
      model[i] = 5'b00000;
    end
    rom[5] = 5'b00010; rom[6] = 5'b00010; rom[1199] = 5'b00100;

    repeat (3) @(posedge Clk);
    #1;
    check("reset_wr_en", 32'(ram_wr_en), 0);
    check("reset_pellets", 32'(pellets_left), 0);
    check("reset_busy", 32'(restore_busy), 0);
    check("reset_addrs", 32'(ram_rd_addr | ram_wr_addr | rom_addr), 0);
    check("reset_pulses", 32'({pellet_eaten, power_eaten, bad_tile, level_clear, restore_done}), 0);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("ready_after_reset", 32'(upd_ready), 1);

    do_restore();
    do_update(5, 0, 5'd0, 0);
    do_update(1199, 1, 5'd0, 0);
    do_update(6, 0, 5'd0, 0);
    do_update(8, 2, 5'b00011, 0);
    do_update(8, 0, 5'd0, 0);
    do_update(7, 0, 5'd0, 0);
    do_update(1200, 0, 5'd0, 0);

    for (int t = 0; t < 80; t++) begin
      int tile;
      tile = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1190, 2047)) : int'($urandom_range(0, 15));
      do_update(tile, int'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 0);
    end

    for (int i = 0; i < NT; i++) rom[i] = 5'($urandom_range(0, 31));
    do_update(3, 2, 5'b01010, 1);
    @(posedge Clk); #1;
    sweep_check();

    for (int t = 0; t < 20; t++)
      do_update(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 0);

    check("pellets_nonzero_before_abort", 32'(pellets_left != 0), 1);
    @(posedge Clk); #1 restore_start = 1'b1;
    @(posedge Clk); #1 restore_start = 1'b0;
    repeat (600) @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(restore_busy), 0);
    check("abort_pellets", 32'(pellets_left), 0);
    check("abort_done", 32'(restore_done), 0);
    check("abort_wr_en", 32'(ram_wr_en), 0);
    $display("reset asserted at sweep cycle 600");
    @(posedge Clk); #1 Reset_n = 1'b1;
    @(negedge Clk);
    check("ready_after_abort", 32'(upd_ready), 1);
    check("busy_after_abort", 32'(restore_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
